// File: rtl/rec_pkg.sv
// rtl/rec_pkg.sv - record word type shared by the record unit, this buffer and the DMA
package rec_pkg;

    localparam int REC_WORD_W = 32;

    typedef logic [REC_WORD_W-1:0] rec_word_t;

endpackage

// File: rtl/sync_word_fifo.sv
// rtl/sync_word_fifo.sv - word FIFO with wrap-flag pointers and a registered fall-through head
module sync_word_fifo
    import rec_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  flush,
    input  logic                  push,
    input  logic [REC_WORD_W-1:0] push_data,
    input  logic                  pop,
    output logic [REC_WORD_W-1:0] head_data,
    output logic                  head_valid,
    output logic                  full,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    rec_word_t       mem_q [DEPTH];
    rec_word_t       mem_d [DEPTH];
    logic [AW:0]     wr_ptr_q, wr_ptr_d;
    logic [AW:0]     rd_ptr_q, rd_ptr_d;
    rec_word_t       head_data_q, head_data_d;
    logic            head_valid_q, head_valid_d;

    always_comb begin
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        head_data_d  = head_data_q;
        head_valid_d = head_valid_q;

        if (flush) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            head_valid_d = 1'b0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q[AW-1:0]] = push_data;
                wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
            end
            // Head is judged against the old write pointer, so a fresh word shows one edge after its write.
            head_valid_d = (wr_ptr_q != rd_ptr_d);
            if (head_valid_d && (!head_valid_q || pop)) begin
                head_data_d = mem_q[rd_ptr_d[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            head_data_q  <= '0;
            head_valid_q <= 1'b0;
        end else begin
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            head_data_q  <= head_data_d;
            head_valid_q <= head_valid_d;
        end
    end

    assign head_data  = head_data_q;
    assign head_valid = head_valid_q;
    assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level      = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/record_word_buffer.sv
// rtl/record_word_buffer.sv - captures record words on rec_valid fall and streams them in packets
module record_word_buffer
    import rec_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int PKT_WORDS = 8,
    parameter int CNT_W     = 16
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    enable,
    input  logic                    flush,
    input  logic [REC_WORD_W-1:0]   rec_word,
    input  logic                    rec_valid,
    output logic [REC_WORD_W-1:0]   m_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    m_last,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    overflow,
    output logic [CNT_W-1:0]        drop_cnt
);

    localparam int                BEAT_W    = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(PKT_WORDS - 1);

    logic              valid_q, valid_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              overflow_q, overflow_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

    logic fall, push_req, pop, push_ok, drop, fifo_full;

    sync_word_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .resetN     (resetN),
        .flush      (flush),
        .push       (push_ok),
        .push_data  (rec_word),
        .pop        (pop),
        .head_data  (m_data),
        .head_valid (m_valid),
        .full       (fifo_full),
        .level      (level)
    );

    always_comb begin
        valid_d    = rec_valid;
        fall       = valid_q & ~rec_valid;
        push_req   = fall & enable;
        pop        = m_valid & m_ready;
        // A full FIFO still takes the word when the head leaves on the same edge.
        push_ok    = push_req & (~fifo_full | pop) & ~flush;
        drop       = push_req & fifo_full & ~pop & ~flush;

        beat_d     = beat_q;
        overflow_d = overflow_q | drop;
        drop_cnt_d = drop_cnt_q;

        if (pop) begin
            beat_d = (beat_q == BEAT_LAST) ? '0 : beat_q + BEAT_W'(1);
        end
        if (drop && (drop_cnt_q != {CNT_W{1'b1}})) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
        if (flush) begin
            beat_d     = '0;
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            valid_q    <= 1'b0;
            beat_q     <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            valid_q    <= valid_d;
            beat_q     <= beat_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign m_last   = m_valid & (beat_q == BEAT_LAST);
    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_record_word_buffer.sv
// tb/tb_record_word_buffer.sv - directed and random stimulus against a queue-based model
module tb_record_word_buffer;

    logic        clk = 1'b0;
    logic        resetN, enable, flush, rec_valid, m_ready;
    logic [31:0] rec_word, m_data;
    logic        m_valid, m_last, overflow;
    logic [4:0]  level;
    logic [15:0] drop_cnt;

    always #5 clk = ~clk;

    record_word_buffer #(
        .DEPTH     (16),
        .PKT_WORDS (8),
        .CNT_W     (16)
    ) dut (
        .clk       (clk),
        .resetN    (resetN),
        .enable    (enable),
        .flush     (flush),
        .rec_word  (rec_word),
        .rec_valid (rec_valid),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last),
        .level     (level),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] q[$];
    bit          valid_e;
    logic [31:0] data_e;
    int          beat_e, drops_e;
    bit          ovf_e, prev_rv;
    int          n_pops, n_lasts, peak;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic model_reset;
        q.delete();
        valid_e = 0; data_e = '0; beat_e = 0; drops_e = 0; ovf_e = 0; prev_rv = 0;
    endtask

    task automatic step;
        bit fall, preq, pop_e, full_e, nv;
        int base;
        fall  = prev_rv && !rec_valid;
        preq  = fall && enable;
        pop_e = valid_e && m_ready;
        if (m_valid && m_ready) begin
            n_pops++;
            if (m_last) n_lasts++;
        end
        if (flush) begin
            q.delete();
            valid_e = 0; beat_e = 0; drops_e = 0; ovf_e = 0;
        end else begin
            full_e = (q.size() == 16);
            base   = q.size() - (pop_e ? 1 : 0);
            if (pop_e) begin
                void'(q.pop_front());
                beat_e = (beat_e + 1) % 8;
            end
            nv = (base > 0);
            if (nv && (pop_e || !valid_e)) data_e = q[0];
            if (preq) begin
                if (!full_e || pop_e) q.push_back(rec_word);
                else begin
                    ovf_e = 1;
                    if (drops_e < 65535) drops_e++;
                end
            end
            valid_e = nv;
        end
        prev_rv = rec_valid;
        @(posedge clk);
        #1;
        if (int'(level) > peak) peak = int'(level);
        chk("m_valid", {31'b0, m_valid}, {31'b0, valid_e});
        chk("level", {27'b0, level}, q.size());
        chk("m_data", m_data, data_e);
        chk("m_last", {31'b0, m_last}, {31'b0, valid_e && (beat_e == 7)});
        chk("overflow", {31'b0, overflow}, {31'b0, ovf_e});
        chk("drop_cnt", {16'b0, drop_cnt}, drops_e);
    endtask

    task automatic pulse(input logic [31:0] w, input int hi, input int lo);
        rec_word  = w;
        rec_valid = 1'b1;
        repeat (hi) step();
        rec_valid = 1'b0;
        step();
        rec_word = $urandom;
        repeat (lo - 1) step();
    endtask

    initial begin
        resetN = 0; enable = 0; flush = 0; rec_valid = 0; m_ready = 0; rec_word = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_m_valid", {31'b0, m_valid}, 32'd0);
        chk("rst_m_data", m_data, 32'd0);
        chk("rst_level", {27'b0, level}, 32'd0);
        chk("rst_drop_cnt", {16'b0, drop_cnt}, 32'd0);
        resetN = 1;

        // In-order delivery through an idle buffer
        enable = 1; m_ready = 1; peak = 0;
        for (int i = 1; i <= 3; i++) pulse(32'hA5A5_0000 + i, 2, 3);
        chk("t1_peak", peak, 32'd1);

        // Overflow with a stalled sink, then drain
        m_ready = 0;
        for (int i = 0; i < 20; i++) pulse(32'h2000 + i, 1, 1);
        chk("t2_level", {27'b0, level}, 32'd16);
        chk("t2_drop", {16'b0, drop_cnt}, 32'd4);
        chk("t2_ovf", {31'b0, overflow}, 32'd1);
        m_ready = 1; n_pops = 0;
        repeat (20) step();
        chk("t2_pops", n_pops, 32'd16);

        // Push and pop on the same edge while full
        m_ready = 0;
        for (int i = 0; i < 16; i++) pulse(32'h3000 + i, 1, 1);
        rec_word = 32'h3FFF; rec_valid = 1; step();
        rec_valid = 0; m_ready = 1; step();
        m_ready = 0;
        chk("t3_level", {27'b0, level}, 32'd16);
        chk("t3_drop", {16'b0, drop_cnt}, 32'd4);
        flush = 1; step(); flush = 0;
        chk("flush_level", {27'b0, level}, 32'd0);

        // Packet framing under random back-pressure
        n_pops = 0; n_lasts = 0;
        for (int i = 0; i < 17; i++) begin
            rec_word = 32'h4000 + i; rec_valid = 1;
            m_ready = ($urandom_range(0, 3) != 0); step();
            rec_valid = 0;
            m_ready = ($urandom_range(0, 3) != 0); step();
        end
        repeat (60) begin
            m_ready = ($urandom_range(0, 3) != 0); step();
        end
        m_ready = 1;
        repeat (20) step();
        chk("t4_pops", n_pops, 32'd17);
        chk("t4_lasts", n_lasts, 32'd2);

        // Capture disabled, then enabled while rec_valid is high
        enable = 0; m_ready = 0;
        for (int i = 0; i < 5; i++) pulse(32'h5000 + i, 1, 1);
        chk("t5_level0", {27'b0, level}, 32'd0);
        chk("t5_drop", {16'b0, drop_cnt}, 32'd0);
        rec_word = 32'h5ABC; rec_valid = 1; step();
        enable = 1; step();
        rec_valid = 0; step(); step();
        chk("t5_level1", {27'b0, level}, 32'd1);
        m_ready = 1;
        repeat (3) step();

        // Flush with words queued and a same-cycle fall
        m_ready = 0;
        for (int i = 0; i < 18; i++) pulse(32'h6000 + i, 1, 1);
        m_ready = 1;
        repeat (10) step();
        m_ready = 0;
        chk("t6_level6", {27'b0, level}, 32'd6);
        rec_word = 32'h6FFF; rec_valid = 1; step();
        rec_valid = 0; flush = 1; m_ready = 1; step();
        flush = 0; m_ready = 0;
        chk("t6_level", {27'b0, level}, 32'd0);
        chk("t6_valid", {31'b0, m_valid}, 32'd0);
        chk("t6_ovf", {31'b0, overflow}, 32'd0);

        // Asynchronous reset mid-drain
        for (int i = 0; i < 4; i++) pulse(32'h7000 + i, 1, 1);
        m_ready = 1; step();
        resetN = 0;
        #2;
        chk("ar_m_valid", {31'b0, m_valid}, 32'd0);
        chk("ar_m_data", m_data, 32'd0);
        chk("ar_m_last", {31'b0, m_last}, 32'd0);
        chk("ar_level", {27'b0, level}, 32'd0);
        chk("ar_overflow", {31'b0, overflow}, 32'd0);
        chk("ar_drop", {16'b0, drop_cnt}, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        resetN = 1;

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            rec_valid = $urandom_range(0, 1);
            rec_word  = $urandom;
            enable    = ($urandom_range(0, 7) != 0);
            m_ready   = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 63) == 0);
            step();
        end
        flush = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
